spi_config_master: RTL and testbench

SPI_CONFIG_MASTER -- requirements
Module: spi_config_master

---
 rtl/spi_config_master.sv | 176 +++++++++++++++++
 tb/tb_spi_config_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_config_master.sv
// SPI master that streams a full configuration frame into a long downstream shift
// register while capturing the previous contents back from its serial output.
//
// state | meaning
// IDLE  | chip select high, waiting for start
// LOAD  | fetching the next 32-bit host word, SCLK low
// LOW   | SCLK low half-period, data bit on spi_sdi
// HIGH  | SCLK high half-period, may stretch while a readback word is unread
// TRAIL | chip select held low for one half-period after the last edge
module spi_config_master #(
  parameter int NBITS = 1280,
  parameter int WORD  = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  input  logic            abort,
  input  logic [7:0]      clk_div,
  input  logic [WORD-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [WORD-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            busy,
  output logic            done,
  output logic            spi_cs_b,
  output logic            spi_sclk,
  output logic            spi_sdi,
  input  logic            spi_sdo,
  inout  wire             vdd_d,
  inout  wire             vss_d
);

  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, TRAIL} state_t;

  state_t          state, state_nxt;
  logic [7:0]      h_lat, h_lat_nxt;
  logic [7:0]      hcnt, hcnt_nxt;
  logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [WORD-1:0] shifter, shifter_nxt;
  logic [WORD-1:0] cap, cap_nxt;
  logic [WORD-1:0] rx_data_nxt;
  logic            rx_valid_nxt, cs_b_nxt, sclk_nxt, sdi_nxt, done_nxt;
  logic            word_end, last_bit;

  wire unused_supply = vdd_d ^ vss_d;

  assign tx_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign word_end = (bit_cnt[4:0] == 5'd31);
  assign last_bit = (bit_cnt == CW'(NBITS - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      h_lat    <= '0;
      hcnt     <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      cap      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_cs_b <= 1'b1;
      spi_sclk <= 1'b0;
      spi_sdi  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      h_lat    <= h_lat_nxt;
      hcnt     <= hcnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shifter  <= shifter_nxt;
      cap      <= cap_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      spi_cs_b <= cs_b_nxt;
      spi_sclk <= sclk_nxt;
      spi_sdi  <= sdi_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    h_lat_nxt    = h_lat;
    hcnt_nxt     = hcnt;
    bit_cnt_nxt  = bit_cnt;
    shifter_nxt  = shifter;
    cap_nxt      = cap;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = rx_valid;
    cs_b_nxt     = spi_cs_b;
    sclk_nxt     = spi_sclk;
    sdi_nxt      = spi_sdi;
    done_nxt     = 1'b0;

    if (rx_valid && rx_ready) rx_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          h_lat_nxt   = clk_div;
          cs_b_nxt    = 1'b0;
          bit_cnt_nxt = '0;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        if (tx_valid) begin
          shifter_nxt = tx_data;
          sdi_nxt     = tx_data[WORD-1];
          hcnt_nxt    = h_lat;
          state_nxt   = LOW;
        end
      end
      LOW: begin
        if (hcnt == 8'd0) begin
          sclk_nxt  = 1'b1;
          cap_nxt   = {cap[WORD-2:0], spi_sdo};
          hcnt_nxt  = h_lat;
          state_nxt = HIGH;
        end else begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      HIGH: begin
        if (hcnt != 8'd0) begin
          hcnt_nxt = hcnt - 8'd1;
        end else if (!(word_end && rx_valid)) begin
          // a finished capture word with the previous one still unread holds SCLK high
          bit_cnt_nxt = bit_cnt + CW'(1);
          sclk_nxt    = 1'b0;
          if (word_end) begin
            rx_data_nxt  = cap;
            rx_valid_nxt = 1'b1;
          end
          if (last_bit) begin
            hcnt_nxt  = h_lat;
            state_nxt = TRAIL;
          end else if (word_end) begin
            state_nxt = LOAD;
          end else begin
            sdi_nxt     = shifter[WORD-2];
            shifter_nxt = {shifter[WORD-2:0], 1'b0};
            hcnt_nxt    = h_lat;
            state_nxt   = LOW;
          end
        end
      end
      TRAIL: begin
        if (hcnt == 8'd0) begin
          cs_b_nxt  = 1'b1;
          sdi_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          hcnt_nxt = hcnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort && state != IDLE) begin
      state_nxt    = IDLE;
      cs_b_nxt     = 1'b1;
      sclk_nxt     = 1'b0;
      sdi_nxt      = 1'b0;
      rx_valid_nxt = 1'b0;
      done_nxt     = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: downstream shift-register model, host tx/rx agents,
// table of frame scenarios and hand sequences for reset/abort/start corner cases.
module tb_spi_config_master;
  localparam int NBITS = 1280;
  localparam int NW    = NBITS / 32;

  logic        clk = 1'b0, rst_b = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0]  clk_div = 8'd3;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0, rx_ready = 1'b1;
  wire         tx_ready, rx_valid, busy, done, spi_cs_b, spi_sclk, spi_sdi, spi_sdo;
  wire  [31:0] rx_data;
  wire         vdd_d = 1'b1;
  wire         vss_d = 1'b0;

  always #5 clk = ~clk;

  spi_config_master #(.NBITS(NBITS), .WORD(32)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .clk_div(clk_div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .done(done), .spi_cs_b(spi_cs_b), .spi_sclk(spi_sclk),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .vdd_d(vdd_d), .vss_d(vss_d)
  );

  // downstream register: shifts in on SCLK rise, MSB drives the readback line
  logic [NBITS-1:0] dreg = '0;
  always @(posedge spi_sclk) dreg <= {dreg[NBITS-2:0], spi_sdi};
  assign spi_sdo = dreg[NBITS-1];

  typedef struct {
    logic [7:0]  div;
    logic [31:0] base;
    int tx_sw, tx_sn, rx_sw, rx_sn, abort_bit;
    int exp_edges, exp_done, exp_tx, exp_rx, exp_hi_long, exp_lo_long;
    bit mess;
  } vec_t;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int h_exp = 4;
  int edges, hi_short, hi_long, lo_short, lo_long, sdi_bad, hold_bad, cs_bad, stall_bad;
  int done_cnt, tx_cnt, rx_cnt, tx_idx = NW, rx_idx, tx_st, rx_st;
  int tx_sw = -1, tx_sn = 0, rx_sw = -1, rx_sn = 0;
  int run = 0, sdi_age = 0;
  logic prev_sclk = 1'b0, prev_sdi = 1'b0, prev_rxv = 1'b0;
  logic tx_take = 1'b0, rx_take = 1'b0, stall, rstall;
  logic [31:0] prev_rxd = '0, tx_base = '0;
  logic [31:0] rxq[$];

  // host agent and SCLK/SDI monitor, all sampled on the falling clock edge
  initial forever begin
    @(negedge clk);
    if (spi_sdi !== prev_sdi) begin
      if (spi_sclk && !spi_cs_b) sdi_bad++;
      sdi_age = 1;
    end else begin
      sdi_age++;
    end
    if (spi_sclk === prev_sclk) begin
      run++;
    end else begin
      if (!spi_cs_b) begin
        if (spi_sclk) begin
          if (edges > 0) begin
            if (run < h_exp) lo_short++;
            else if (run > h_exp + 1) lo_long++;
          end
          if (sdi_age <= h_exp) sdi_bad++;
          edges++;
        end else begin
          if (run < h_exp) hi_short++;
          else if (run > h_exp) hi_long++;
        end
      end
      run = 1;
    end
    prev_sclk = spi_sclk;
    prev_sdi  = spi_sdi;
    if (done) begin
      done_cnt++;
      if (!spi_cs_b || busy) cs_bad++;
    end
    if (prev_rxv && !rx_take && rx_valid && rx_data !== prev_rxd) hold_bad++;

    if (tx_take) begin tx_cnt++; tx_idx++; end
    stall = (tx_idx == tx_sw) && (tx_st < tx_sn);
    if (stall && tx_ready) begin
      tx_st++;
      if (spi_sclk) stall_bad++;
    end
    tx_valid = (tx_idx < NW) && !stall;
    tx_data  = tx_base + 32'(tx_idx);
    tx_take  = tx_valid && tx_ready;

    rstall = (rx_idx == rx_sw) && (rx_st < rx_sn);
    if (rstall && rx_valid) rx_st++;
    rx_ready = !rstall;
    rx_take  = rx_valid && rx_ready;
    if (rx_take) begin
      rx_cnt++;
      rx_idx++;
      if (rxq.size() == 0) check("rx_extra_word", 1, 0);
      else check("rx_data", rx_data, rxq.pop_front());
    end
    prev_rxv = rx_valid;
    prev_rxd = rx_data;
  end

  task automatic begin_frame(input vec_t v);
    @(negedge clk);
    h_exp = int'(v.div) + 1;
    tx_base = v.base; tx_sw = v.tx_sw; tx_sn = v.tx_sn; rx_sw = v.rx_sw; rx_sn = v.rx_sn;
    edges = 0; hi_short = 0; hi_long = 0; lo_short = 0; lo_long = 0; sdi_bad = 0;
    hold_bad = 0; cs_bad = 0; stall_bad = 0; done_cnt = 0; tx_cnt = 0; rx_cnt = 0;
    tx_idx = 0; rx_idx = 0; tx_st = 0; rx_st = 0;
    rxq.delete();
    for (int k = 0; k < NW; k++) rxq.push_back(dreg[NBITS-1-32*k -: 32]);
    @(negedge clk);
    clk_div = v.div;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {busy, spi_cs_b}, 2'b10);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int cyc;
    int wbad;
    begin_frame(v);
    cyc = 0;
    while (done_cnt == 0 && cyc < 30000 && !(v.abort_bit >= 0 && edges >= v.abort_bit)) begin
      @(negedge clk);
      cyc++;
      if (v.mess) begin
        start = (edges == 100 || edges == 700);
        if (edges == 100) clk_div = 8'd3;
        if (edges == 700) clk_div = 8'd200;
      end
    end
    start = 1'b0;
    check({tag, "_timeout"}, cyc >= 30000, 0);
    if (v.abort_bit >= 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({tag, "_abort_outs"}, {spi_cs_b, spi_sclk, spi_sdi, rx_valid, tx_ready, busy},
            6'b100000);
      rxq.delete();
    end
    repeat (3 * h_exp + 10) @(negedge clk);
    check({tag, "_edges"}, edges, v.exp_edges);
    check({tag, "_done_pulses"}, done_cnt, v.exp_done);
    check({tag, "_tx_words"}, tx_cnt, v.exp_tx);
    check({tag, "_rx_words"}, rx_cnt, v.exp_rx);
    check({tag, "_short_phases"}, hi_short + lo_short, 0);
    check({tag, "_long_high"}, hi_long, v.exp_hi_long);
    check({tag, "_long_low"}, lo_long, v.exp_lo_long);
    check({tag, "_sdi_timing"}, sdi_bad, 0);
    check({tag, "_rx_hold"}, hold_bad, 0);
    check({tag, "_done_cs"}, cs_bad, 0);
    check({tag, "_tx_stall_sclk"}, stall_bad, 0);
    check({tag, "_idle_busy"}, busy, 0);
    if (v.exp_done != 0) begin
      wbad = 0;
      for (int k = 0; k < NW; k++)
        if (dreg[NBITS-1-32*k -: 32] !== v.base + 32'(k)) wbad++;
      check({tag, "_dreg_top"}, dreg[NBITS-1 -: 32], v.base);
      check({tag, "_dreg_bottom"}, dreg[31:0], v.base + 32'(NW - 1));
      check({tag, "_dreg_words"}, wbad, 0);
      check({tag, "_rx_missing"}, rxq.size(), 0);
    end
  endtask

  vec_t vecs[5];
  vec_t hv;
  int   cyc;

  initial begin
    vecs[0] = '{8'd3, 32'hA5A50000, -1, 0, -1, 0,  -1, 1280, 1, 40, 40, 0, 0, 1'b0};
    vecs[1] = '{8'd3, 32'h3C3C0000,  5, 20, -1, 0, -1, 1280, 1, 40, 40, 0, 1, 1'b0};
    vecs[2] = '{8'd3, 32'h5A5A0000, -1, 0, 10, 300, -1, 1280, 1, 40, 40, 1, 0, 1'b0};
    vecs[3] = '{8'd3, 32'h0F0F0000, -1, 0, -1, 0, 600, 600, 0, 19, 18, 0, 0, 1'b0};
    vecs[4] = '{8'd3, 32'hC3C30000, -1, 0, -1, 0,  -1, 1280, 1, 40, 40, 0, 0, 1'b0};

    #2 rst_b = 1'b0;
    #1;
    check("reset_outs", {spi_cs_b, spi_sclk, spi_sdi, tx_ready, rx_valid, busy, done},
          7'b1000000);
    check("reset_rx_data", rx_data, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_start", {busy, spi_cs_b}, 2'b01);

    hv = '{8'd4, 32'h12340000, -1, 0, -1, 0, -1, 1280, 1, 40, 40, 0, 0, 1'b1};
    run_frame(hv, "divchg");

    hv = '{8'd3, 32'h77770000, -1, 0, -1, 0, -1, 1280, 1, 40, 40, 0, 0, 1'b0};
    begin_frame(hv);
    cyc = 0;
    while (!(edges >= 40 && spi_sclk) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_wait_timeout", cyc >= 2000, 0);
    rst_b = 1'b0;
    #1;
    check("rst_mid_high", {spi_cs_b, spi_sclk, spi_sdi, busy, rx_valid, tx_ready, done},
          7'b1000000);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
